// File: rtl/decodificador_pkg.sv
// Shared definitions for the registered one-hot decoder family.
package decodificador_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int unsigned ONEHOT_MAX_W = 32;

   // One-hot encode idx into a vector whose meaningful width is 'width' (<= 32).
   function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [4:0] idx,
                                                       input int unsigned width);
      logic [ONEHOT_MAX_W-1:0] v;
      v = '0;
      if (32'(idx) < width) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decodificador_scan_if.sv
// Control/status bundle between the controller and the scan decoder.
interface decodificador_scan_if #(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned DIV_W = 16
);
   localparam int unsigned N = 1 << SEL_W;

   logic             en;
   logic             mode;
   logic [SEL_W-1:0] sel_in;
   logic             sel_valid;
   logic             div_load;
   logic [DIV_W-1:0] div_val;
   logic [N-1:0]     out;
   logic [SEL_W-1:0] idx;
   logic             tick;

   modport master (
      output en, mode, sel_in, sel_valid, div_load, div_val,
      input  out, idx, tick
   );

   modport slave (
      input  en, mode, sel_in, sel_valid, div_load, div_val,
      output out, idx, tick
   );
endinterface

// File: rtl/decodificador_scan_prescaler.sv
// Programmable prescaler: counts 0..div_reg and flags the terminal count.
module scan_prescaler #(
   parameter int unsigned    DIV_W     = 16,
   parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(49999)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] div_val_i,
   output logic             tc_c
);

   logic [DIV_W-1:0] presc_q, presc_d;
   logic [DIV_W-1:0] div_q, div_d;

   // Load beats clear beats counting; tc only fires on an undisturbed terminal count.
   always_comb begin
      presc_d = presc_q;
      div_d   = div_q;
      tc_c    = 1'b0;
      if (load_i) begin
         div_d   = div_val_i;
         presc_d = '0;
      end else if (clear_i) begin
         presc_d = '0;
      end else if (run_i) begin
         if (presc_q == div_q) begin
            presc_d = '0;
            tc_c    = 1'b1;
         end else begin
            presc_d = presc_q + DIV_W'(1);
         end
      end
   end

   // Prescaler and divider registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         div_q   <= DIV_RESET;
      end else begin
         presc_q <= presc_d;
         div_q   <= div_d;
      end
   end

endmodule

// File: rtl/decodificador_scan.sv
// Registered one-hot decoder with direct-index and auto-scan modes.
module decodificador_scan
   import decodificador_pkg::*;
#(
   parameter int unsigned      SEL_W      = 3,
   parameter int unsigned      DIV_W      = 16,
   parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(49999),
   parameter bit               ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst,
   decodificador_scan_if.slave bus
);

   localparam int unsigned N = 1 << SEL_W;
   localparam logic [N-1:0] BLANK = {N{ACTIVE_LOW}};

   logic [SEL_W-1:0] idx_q, idx_d;
   logic [N-1:0]     out_q, out_d;
   logic             tick_q, tick_d;
   logic             mode_q, mode_d;
   logic [N-1:0]     oh_c;
   logic             mode_chg_c;
   logic             run_c;
   logic             tc_c;

   // A mode switch only counts on enabled edges; it restarts the prescaler.
   assign mode_chg_c = bus.en && (bus.mode != mode_q);
   assign run_c      = bus.en && (bus.mode == MODE_SCAN);

   scan_prescaler #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
   ) u_presc (
      .clk       (clk),
      .rst       (rst),
      .run_i     (run_c),
      .clear_i   (mode_chg_c),
      .load_i    (bus.div_load),
      .div_val_i (bus.div_val),
      .tc_c      (tc_c)
   );

   // Next index, tick and (optionally inverted) decoded output.
   always_comb begin
      idx_d  = idx_q;
      tick_d = 1'b0;
      mode_d = mode_q;
      out_d  = BLANK;
      oh_c   = '0;
      if (bus.en) begin
         mode_d = bus.mode;
         if (bus.mode == MODE_DIRECT) begin
            if (bus.sel_valid) idx_d = bus.sel_in;
         end else if (tc_c) begin
            idx_d  = idx_q + SEL_W'(1);
            tick_d = 1'b1;
         end
         oh_c  = N'(onehot(5'(idx_d), N));
         out_d = ACTIVE_LOW ? ~oh_c : oh_c;
      end
   end

   // Output, index and mode registers; reset blanks the lines immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         out_q  <= BLANK;
         tick_q <= 1'b0;
         mode_q <= MODE_DIRECT;
      end else begin
         idx_q  <= idx_d;
         out_q  <= out_d;
         tick_q <= tick_d;
         mode_q <= mode_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.idx  = idx_q;
   assign bus.tick = tick_q;

endmodule

// File: tb/tb_decodificador_scan.sv
// Directed self-checking bench for decodificador_scan (two parameter sets).
module tb_decodificador_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decodificador_scan_if #(.SEL_W(3), .DIV_W(16)) b1 ();
   decodificador_scan_if #(.SEL_W(2), .DIV_W(16)) b2 ();

   decodificador_scan #(.SEL_W(3), .DIV_W(16), .DIV_RESET(16'd49999), .ACTIVE_LOW(1'b0))
      dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   decodificador_scan #(.SEL_W(2), .DIV_W(16), .DIV_RESET(16'd49999), .ACTIVE_LOW(1'b1))
      dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

   int n_checks = 0;
   int n_fail   = 0;
   logic [2:0] exp_idx;
   logic [7:0] exp_out;
   logic       exp_tick;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_checks++; if (b1.out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected %h", b1.out, 8'h00); end
      n_checks++; if (b1.idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected %0d", b1.idx, 0); end
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected %b", b1.tick, 1'b0); end
      n_checks++; if (b2.out !== 4'hF) begin n_fail++; $display("FAIL reset_out_al: got %h expected %h", b2.out, 4'hF); end
      #2 rst = 1'b0;
      step();
      n_checks++; if (b1.out !== 8'h00) begin n_fail++; $display("FAIL post_reset_disabled: got %h expected %h", b1.out, 8'h00); end
   endtask

   task automatic test_direct();
      b1.en = 1'b1; b1.mode = 1'b0; b1.sel_in = 3'd5; b1.sel_valid = 1'b1;
      step();
      n_checks++; if (b1.out !== 8'h20) begin n_fail++; $display("FAIL direct_out: got %h expected %h", b1.out, 8'h20); end
      n_checks++; if (b1.idx !== 3'd5) begin n_fail++; $display("FAIL direct_idx: got %0d expected %0d", b1.idx, 5); end
      b1.sel_valid = 1'b0; b1.sel_in = 3'd2;
      step();
      n_checks++; if (b1.out !== 8'h20) begin n_fail++; $display("FAIL direct_hold_out: got %h expected %h", b1.out, 8'h20); end
      n_checks++; if (b1.idx !== 3'd5) begin n_fail++; $display("FAIL direct_hold_idx: got %0d expected %0d", b1.idx, 5); end
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL direct_tick: got %b expected %b", b1.tick, 1'b0); end
   endtask

   task automatic test_scan_wrap();
      b1.sel_in = 3'd6; b1.sel_valid = 1'b1;
      step();
      b1.sel_valid = 1'b0; b1.div_load = 1'b1; b1.div_val = 16'd2;
      step();
      b1.div_load = 1'b0; b1.mode = 1'b1;
      step();
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL scan_modechg_tick: got %b expected %b", b1.tick, 1'b0); end
      n_checks++; if (b1.out !== 8'h40) begin n_fail++; $display("FAIL scan_start_out: got %h expected %h", b1.out, 8'h40); end
      exp_idx = 3'd6;
      for (int c = 1; c <= 9; c++) begin
         step();
         exp_tick = ((c % 3) == 0);
         if (exp_tick) exp_idx = exp_idx + 3'd1;
         exp_out = 8'b1 << exp_idx;
         n_checks++; if (b1.tick !== exp_tick) begin n_fail++; $display("FAIL scan_tick[%0d]: got %b expected %b", c, b1.tick, exp_tick); end
         n_checks++; if (b1.idx !== exp_idx) begin n_fail++; $display("FAIL scan_idx[%0d]: got %0d expected %0d", c, b1.idx, exp_idx); end
         n_checks++; if (b1.out !== exp_out) begin n_fail++; $display("FAIL scan_out[%0d]: got %h expected %h", c, b1.out, exp_out); end
      end
   endtask

   task automatic test_div_zero();
      b1.div_load = 1'b1; b1.div_val = 16'd0;
      step();
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL div0_load_tick: got %b expected %b", b1.tick, 1'b0); end
      n_checks++; if (b1.idx !== exp_idx) begin n_fail++; $display("FAIL div0_load_idx: got %0d expected %0d", b1.idx, exp_idx); end
      b1.div_load = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         exp_idx = exp_idx + 3'd1;
         exp_out = 8'b1 << exp_idx;
         n_checks++; if (b1.tick !== 1'b1) begin n_fail++; $display("FAIL div0_tick[%0d]: got %b expected %b", c, b1.tick, 1'b1); end
         n_checks++; if (b1.out !== exp_out) begin n_fail++; $display("FAIL div0_out[%0d]: got %h expected %h", c, b1.out, exp_out); end
      end
   endtask

   task automatic test_load_priority();
      b1.div_load = 1'b1; b1.div_val = 16'd3;
      step();
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL prio_load3_tick: got %b expected %b", b1.tick, 1'b0); end
      b1.div_load = 1'b0;
      repeat (3) step();
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL prio_pre_tick: got %b expected %b", b1.tick, 1'b0); end
      b1.div_load = 1'b1; b1.div_val = 16'd5;
      step();
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL prio_tc_edge_tick: got %b expected %b", b1.tick, 1'b0); end
      n_checks++; if (b1.idx !== exp_idx) begin n_fail++; $display("FAIL prio_tc_edge_idx: got %0d expected %0d", b1.idx, exp_idx); end
      b1.div_load = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         step();
         exp_tick = (c == 6);
         if (exp_tick) exp_idx = exp_idx + 3'd1;
         n_checks++; if (b1.tick !== exp_tick) begin n_fail++; $display("FAIL prio_tick[%0d]: got %b expected %b", c, b1.tick, exp_tick); end
      end
      n_checks++; if (b1.idx !== exp_idx) begin n_fail++; $display("FAIL prio_idx: got %0d expected %0d", b1.idx, exp_idx); end
   endtask

   task automatic test_enable_reset_midscan();
      b1.mode = 1'b0; b1.sel_in = 3'd4; b1.sel_valid = 1'b1;
      step();
      b1.sel_valid = 1'b0; b1.mode = 1'b1; b1.div_load = 1'b1; b1.div_val = 16'd3;
      step();
      n_checks++; if (b1.out !== 8'h10) begin n_fail++; $display("FAIL en_start_out: got %h expected %h", b1.out, 8'h10); end
      b1.div_load = 1'b0; b1.en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         n_checks++; if (b1.out !== 8'h00) begin n_fail++; $display("FAIL dis_out[%0d]: got %h expected %h", c, b1.out, 8'h00); end
         n_checks++; if (b1.idx !== 3'd4) begin n_fail++; $display("FAIL dis_idx[%0d]: got %0d expected %0d", c, b1.idx, 4); end
         n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL dis_tick[%0d]: got %b expected %b", c, b1.tick, 1'b0); end
      end
      b1.en = 1'b1;
      step();
      n_checks++; if (b1.out !== 8'h10) begin n_fail++; $display("FAIL reen_out: got %h expected %h", b1.out, 8'h10); end
      repeat (2) step();
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL reen_early_tick: got %b expected %b", b1.tick, 1'b0); end
      step();
      n_checks++; if (b1.tick !== 1'b1) begin n_fail++; $display("FAIL reen_tick: got %b expected %b", b1.tick, 1'b1); end
      n_checks++; if (b1.out !== 8'h20) begin n_fail++; $display("FAIL reen_out_adv: got %h expected %h", b1.out, 8'h20); end
      #3 rst = 1'b1;
      #1;
      n_checks++; if (b1.out !== 8'h00) begin n_fail++; $display("FAIL async_rst_out: got %h expected %h", b1.out, 8'h00); end
      n_checks++; if (b1.idx !== 3'd0) begin n_fail++; $display("FAIL async_rst_idx: got %0d expected %0d", b1.idx, 0); end
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL async_rst_tick: got %b expected %b", b1.tick, 1'b0); end
      #1 rst = 1'b0;
      step();
      n_checks++; if (b1.out !== 8'h01) begin n_fail++; $display("FAIL post_rst_out: got %h expected %h", b1.out, 8'h01); end
      n_checks++; if (b1.tick !== 1'b0) begin n_fail++; $display("FAIL post_rst_tick: got %b expected %b", b1.tick, 1'b0); end
   endtask

   task automatic test_active_low_small();
      b2.en = 1'b1; b2.mode = 1'b0; b2.sel_in = 2'd2; b2.sel_valid = 1'b1;
      step();
      n_checks++; if (b2.out !== 4'hB) begin n_fail++; $display("FAIL al_out: got %h expected %h", b2.out, 4'hB); end
      n_checks++; if (b2.idx !== 2'd2) begin n_fail++; $display("FAIL al_idx: got %0d expected %0d", b2.idx, 2); end
      b2.sel_valid = 1'b0; b2.en = 1'b0;
      step();
      n_checks++; if (b2.out !== 4'hF) begin n_fail++; $display("FAIL al_blank: got %h expected %h", b2.out, 4'hF); end
      n_checks++; if (b2.idx !== 2'd2) begin n_fail++; $display("FAIL al_hold_idx: got %0d expected %0d", b2.idx, 2); end
   endtask

   initial begin
      b1.en = 1'b0; b1.mode = 1'b0; b1.sel_in = '0; b1.sel_valid = 1'b0;
      b1.div_load = 1'b0; b1.div_val = '0;
      b2.en = 1'b0; b2.mode = 1'b0; b2.sel_in = '0; b2.sel_valid = 1'b0;
      b2.div_load = 1'b0; b2.div_val = '0;
      test_reset();
      test_direct();
      test_scan_wrap();
      test_div_zero();
      test_load_priority();
      test_enable_reset_midscan();
      test_active_low_small();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
